hdmi_tx: RTL and testbench
==========================

Name: hdmi_tx

Overview:
- Single-clock HDMI/DVI video transmitter core.
- Generates CEA-861 raster timing and exposes the current pixel position (cx, cy) so upstream logic (e.g. the NES frame-buffer scaler) can supply rgb.
- Produces three parallel 10-bit TMDS symbols per pixel clock plus a constant clock-channel pattern. An external 10:1 serializer and LVDS buffers drive the pins.
- Audio packet/data-island generation is out of scope for this block.

Parameters:
- VIDEO_ID_CODE, 4: 4 = 1280x720p; 1 = 640x480p. Any other value is unsupported.
- VIDEO_REFRESH_RATE, 60: informational only; must be 60.
- DVI_OUTPUT, 0: 1 = pure DVI (no preamble or guard band); 0 = HDMI video preamble plus guard band.
- START_X, 0: cx value loaded on reset.
- START_Y, 0: cy value loaded on reset.

Ports:
- clk_pixel  in  1  pixel clock; all logic runs on its rising edge.
- reset  in  1  synchronous, active-high.
- rgb  in  24  pixel colour: [23:16] R to ch2, [15:8] G to ch1, [7:0] B to ch0.
- tmds  out  30  {ch2, ch1, ch0} 10-bit symbols; bit 0 is transmitted first.
- tmds_clock  out  10  constant 10'b0000011111.
- cx  out  11  current column.
- cy  out  10  current line.
- frame_width  out  11  total columns per line (constant).
- frame_height  out  10  total lines per frame (constant).

Behaviour:
- Timing table (active / front porch / sync / back porch / total):
  - Code 4, horizontal: 1280 / 110 / 40 / 220 / 1650. Vertical: 720 / 5 / 5 / 20 / 750. Sync polarity positive.
  - Code 1, horizontal: 640 / 16 / 96 / 48 / 800. Vertical: 480 / 10 / 2 / 33 / 525. Sync polarity negative.
- Counters:
  - cx increments every clock. At frame_width-1 it wraps to 0 and cy increments.
  - cy wraps from frame_height-1 to 0.
  - On reset: cx=START_X, cy=START_Y.
- Active region: cx<W and cy<H, with blanking following.
  - hsync is asserted for cx in [W+HFP, W+HFP+HS).
  - vsync is asserted for cy in [H+VFP, H+VFP+VS).
  - Polarity comes from the table above.
- Position association: rgb sampled in the cycle where cx/cy show (X,Y) is treated as pixel (X,Y).
  - All mode decisions (data / control / preamble / guard) use that same cycle's cx/cy.
  - The resulting symbols appear on tmds exactly 2 clocks later. Latency is fixed in every mode.
- Data period: each channel uses the standard DVI 8b/10b algorithm.
  - Stage 1: XOR/XNOR minimisation. Select XNOR when N1(D)>4, or when N1(D)==4 and D[0]==0.
  - Stage 2: DC balancing with a signed running disparity cnt (ones minus zeros), one per channel.
  - cnt is cleared to 0 on reset and in every non-data cycle.
- Control period symbols (per channel, {C1,C0}):
  - 00 = 1101010100, 01 = 0010101011, 10 = 0101010100, 11 = 1010101011 (bit9..bit0).
  - ch0 carries {vsync, hsync}.
  - ch1 and ch2 carry CTL bits, which are 00 except during the preamble.
- HDMI mode (DVI_OUTPUT=0), applied on any line whose next line is active (cy=frame_height-1, or cy<H-1):
  - Video preamble for cx in [frame_width-10, frame_width-3]: ch1 C=01, ch2 C=00, ch0 still carries syncs.
  - Guard band for cx in [frame_width-2, frame_width-1]: ch0=1011001100, ch1=0100110011, ch2=1011001100.
- DVI mode (DVI_OUTPUT=1): these cycles are ordinary control periods.
- Reset:
  - The tmds register and the 2-stage pipeline load control token 00 on all channels (1101010100 each).
  - Sync levels are taken as 0 for this reset value.
  - The first post-reset symbols appear 2 clocks after reset deasserts.
- Reset mid-frame takes effect on the next edge. No partial-pipeline symbols are emitted afterwards.
- frame_width and frame_height are constant outputs that are valid during reset.

Test Plan:
- Reset, code 4, START 0/0 -> cx=0, cy=0, tmds=3x1101010100, frame_width=1650, frame_height=750, tmds_clock=0000011111.
- Free-run 1650*750 clocks -> cx 1649->0 with cy+1; cy 749->0; hsync (ch0 C0) high exactly for cx 1390..1429; vsync for cy 725..729.
- Constant rgb=000000 in active area from line start (cnt=0) -> ch0 symbols 0100000000, 1111111111, 0100000000 … with 2-clock latency; first blank pixel is a control token.
- rgb B=FF at first active pixel, cnt=0 -> ch0=1000000000.
- DVI_OUTPUT=0 -> on cy=749 at cx 1640..1647, ch1=0010101011 and ch2=1101010100; at cx 1648..1649, guard symbols as specified. DVI_OUTPUT=1 -> plain control tokens.
- Code 1 -> frame 800x525; hsync inactive level is 1 (ch0 C0=1 outside cx 656..751).

Source files
------------

// File: rtl/hdmi_tx.sv
// hdmi_tx: CEA-861 raster timing generator with three-channel TMDS video encoding.
// Symbols for the pixel shown on (cx, cy) leave on tmds exactly two clocks later.
module hdmi_tx #(
   parameter int VIDEO_ID_CODE      = 4,
   parameter int VIDEO_REFRESH_RATE = 60,
   parameter bit DVI_OUTPUT         = 1'b0,
   parameter int START_X            = 0,
   parameter int START_Y            = 0
) (
   input  logic        clk_pixel,
   input  logic        reset,
   input  logic [23:0] rgb,
   output logic [29:0] tmds,
   output logic [9:0]  tmds_clock,
   output logic [10:0] cx,
   output logic [9:0]  cy,
   output logic [10:0] frame_width,
   output logic [9:0]  frame_height
);

   if (!(VIDEO_ID_CODE == 1 || VIDEO_ID_CODE == 4) || VIDEO_REFRESH_RATE != 60) begin : g_bad_cfg
      $error("hdmi_tx: unsupported VIDEO_ID_CODE / VIDEO_REFRESH_RATE");
   end

   localparam bit MODE_720P = (VIDEO_ID_CODE == 4);

   localparam logic [10:0] H_ACTIVE = MODE_720P ? 11'd1280 : 11'd640;
   localparam logic [10:0] H_FP     = MODE_720P ? 11'd110  : 11'd16;
   localparam logic [10:0] H_SYNC   = MODE_720P ? 11'd40   : 11'd96;
   localparam logic [10:0] H_TOTAL  = MODE_720P ? 11'd1650 : 11'd800;
   localparam logic [9:0]  V_ACTIVE = MODE_720P ? 10'd720  : 10'd480;
   localparam logic [9:0]  V_FP     = MODE_720P ? 10'd5    : 10'd10;
   localparam logic [9:0]  V_SYNC   = MODE_720P ? 10'd5    : 10'd2;
   localparam logic [9:0]  V_TOTAL  = MODE_720P ? 10'd750  : 10'd525;
   // 640x480 uses negative sync polarity, so its idle sync level is 1.
   localparam bit          SYNC_INV = !MODE_720P;

   localparam logic [10:0] HS_START = H_ACTIVE + H_FP;
   localparam logic [10:0] HS_END   = HS_START + H_SYNC;
   localparam logic [9:0]  VS_START = V_ACTIVE + V_FP;
   localparam logic [9:0]  VS_END   = VS_START + V_SYNC;

   localparam logic [9:0] CTRL_00 = 10'b1101010100;
   localparam logic [9:0] CTRL_01 = 10'b0010101011;
   localparam logic [9:0] CTRL_10 = 10'b0101010100;
   localparam logic [9:0] CTRL_11 = 10'b1010101011;
   localparam logic [9:0] GUARD_B = 10'b1011001100;
   localparam logic [9:0] GUARD_G = 10'b0100110011;

   typedef enum logic [1:0] {
      PER_CTRL  = 2'd0,
      PER_DATA  = 2'd1,
      PER_GUARD = 2'd2
   } period_e;

   function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
      logic [9:0] s;
      case (c)
         2'b00:   s = CTRL_00;
         2'b01:   s = CTRL_01;
         2'b10:   s = CTRL_10;
         default: s = CTRL_11;
      endcase
      return s;
   endfunction

   logic [10:0] cx_q, cx_d;
   logic [9:0]  cy_q, cy_d;

   always_comb begin
      cx_d = cx_q + 11'd1;
      cy_d = cy_q;
      if (cx_q == H_TOTAL - 11'd1) begin
         cx_d = '0;
         cy_d = (cy_q == V_TOTAL - 10'd1) ? '0 : cy_q + 10'd1;
      end
   end

   // Position decode: everything here belongs to the pixel currently on cx/cy.
   logic    video_on;
   logic    hsync;
   logic    vsync;
   logic    next_line_on;
   logic    in_preamble;
   logic    in_guard;
   period_e period_d;

   always_comb begin
      video_on     = (cx_q < H_ACTIVE) && (cy_q < V_ACTIVE);
      hsync        = ((cx_q >= HS_START) && (cx_q < HS_END)) ^ SYNC_INV;
      vsync        = ((cy_q >= VS_START) && (cy_q < VS_END)) ^ SYNC_INV;
      next_line_on = (cy_q == V_TOTAL - 10'd1) || (cy_q < V_ACTIVE - 10'd1);
      in_preamble  = !DVI_OUTPUT && next_line_on &&
                     (cx_q >= H_TOTAL - 11'd10) && (cx_q <= H_TOTAL - 11'd3);
      in_guard     = !DVI_OUTPUT && next_line_on && (cx_q >= H_TOTAL - 11'd2);
      period_d     = PER_CTRL;
      if (video_on) begin
         period_d = PER_DATA;
      end else if (in_guard) begin
         period_d = PER_GUARD;
      end
   end

   period_e     period_q;
   logic [23:0] rgb_q;
   logic [1:0]  sync_q;
   logic        pre_q;
   logic [29:0] tmds_q, tmds_d;

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         cx_q     <= 11'(START_X);
         cy_q     <= 10'(START_Y);
         period_q <= PER_CTRL;
         rgb_q    <= '0;
         sync_q   <= 2'b00;
         pre_q    <= 1'b0;
         tmds_q   <= {3{CTRL_00}};
      end else begin
         cx_q     <= cx_d;
         cy_q     <= cy_d;
         period_q <= period_d;
         rgb_q    <= rgb;
         sync_q   <= {vsync, hsync};
         pre_q    <= in_preamble;
         tmds_q   <= tmds_d;
      end
   end

   logic [9:0] enc_sym [0:2];

   // One 8b/10b encoder per channel: ch0 = blue, ch1 = green, ch2 = red.
   for (genvar ch = 0; ch < 3; ch++) begin : g_enc
      logic [7:0]        d;
      logic [3:0]        n1d;
      logic [3:0]        n1q;
      logic              use_xnor;
      logic [8:0]        qm;
      logic signed [5:0] diff;
      logic signed [5:0] cnt_q, cnt_d;
      logic [9:0]        sym;

      assign d = rgb_q[ch*8 +: 8];

      always_comb begin
         n1d      = 4'($countones(d));
         use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
         qm       = '0;
         qm[0]    = d[0];
         for (int i = 1; i < 8; i++) begin
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
         end
         qm[8] = ~use_xnor;
         n1q   = 4'($countones(qm[7:0]));
         // diff is ones minus zeros of the minimised byte.
         diff  = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
         sym   = {1'b0, qm[8], qm[7:0]};
         cnt_d = cnt_q;
         if (cnt_q == 6'sd0 || diff == 6'sd0) begin
            sym   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cnt_d = qm[8] ? cnt_q + diff : cnt_q - diff;
         end else if ((cnt_q > 6'sd0 && diff > 6'sd0) || (cnt_q < 6'sd0 && diff < 6'sd0)) begin
            sym   = {1'b1, qm[8], ~qm[7:0]};
            cnt_d = cnt_q + $signed({4'b0000, qm[8], 1'b0}) - diff;
         end else begin
            sym   = {1'b0, qm[8], qm[7:0]};
            cnt_d = cnt_q - $signed({4'b0000, ~qm[8], 1'b0}) + diff;
         end
      end

      always_ff @(posedge clk_pixel) begin
         if (reset || period_q != PER_DATA) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign enc_sym[ch] = sym;
   end

   always_comb begin
      tmds_d = {CTRL_00, pre_q ? CTRL_01 : CTRL_00, ctrl_sym(sync_q)};
      case (period_q)
         PER_DATA:  tmds_d = {enc_sym[2], enc_sym[1], enc_sym[0]};
         PER_GUARD: tmds_d = {GUARD_B, GUARD_G, GUARD_B};
         default:   ;
      endcase
   end

   assign tmds         = tmds_q;
   assign tmds_clock   = 10'b0000011111;
   assign cx           = cx_q;
   assign cy           = cy_q;
   assign frame_width  = H_TOTAL;
   assign frame_height = V_TOTAL;

endmodule

// File: tb/tb_hdmi_tx.sv
// tb_hdmi_tx: scoreboard bench for hdmi_tx; a reference model pushes expected symbols
// per driven pixel and each is popped when the DUT emits it two clocks later.
module tb_hdmi_tx;

   localparam logic [9:0] T00 = 10'b1101010100;
   localparam logic [9:0] T01 = 10'b0010101011;
   localparam logic [9:0] T10 = 10'b0101010100;
   localparam logic [9:0] T11 = 10'b1010101011;
   localparam logic [9:0] GB  = 10'b1011001100;
   localparam logic [9:0] GG  = 10'b0100110011;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_m = 1'b1, rst_f = 1'b1, rst_d = 1'b1;
   logic [23:0] rgb_m = '0, rgb_f = '0, rgb_d = '0;
   logic [29:0] tmds_m, tmds_f, tmds_d;
   logic [9:0]  tclk_m, tclk_f, tclk_d;
   logic [10:0] cx_m, cx_f, cx_d;
   logic [9:0]  cy_m, cy_f, cy_d;
   logic [10:0] fw_m, fw_f, fw_d;
   logic [9:0]  fh_m, fh_f, fh_d;

   hdmi_tx #(.VIDEO_ID_CODE(4), .VIDEO_REFRESH_RATE(60), .DVI_OUTPUT(1'b0),
             .START_X(0), .START_Y(0)) u_main (
      .clk_pixel(clk), .reset(rst_m), .rgb(rgb_m), .tmds(tmds_m), .tmds_clock(tclk_m),
      .cx(cx_m), .cy(cy_m), .frame_width(fw_m), .frame_height(fh_m));

   hdmi_tx #(.VIDEO_ID_CODE(4), .VIDEO_REFRESH_RATE(60), .DVI_OUTPUT(1'b0),
             .START_X(1300), .START_Y(724)) u_frame (
      .clk_pixel(clk), .reset(rst_f), .rgb(rgb_f), .tmds(tmds_f), .tmds_clock(tclk_f),
      .cx(cx_f), .cy(cy_f), .frame_width(fw_f), .frame_height(fh_f));

   hdmi_tx #(.VIDEO_ID_CODE(1), .VIDEO_REFRESH_RATE(60), .DVI_OUTPUT(1'b1),
             .START_X(600), .START_Y(520)) u_dvi (
      .clk_pixel(clk), .reset(rst_d), .rgb(rgb_d), .tmds(tmds_d), .tmds_clock(tclk_d),
      .cx(cx_d), .cy(cy_d), .frame_width(fw_d), .frame_height(fh_d));

   int checks   = 0;
   int failures = 0;

   // ---------------- reference model + scoreboard ----------------
   logic [29:0] exp_q[$];
   int          pos_q[$];
   int          m_code;
   bit          m_dvi;
   int          mx, my;
   int          mcnt[3];

   function automatic logic [9:0] ctok(input logic [1:0] c);
      case (c)
         2'b00:   return T00;
         2'b01:   return T01;
         2'b10:   return T10;
         default: return T11;
      endcase
   endfunction

   task automatic enc_model(input logic [7:0] d, input int cin,
                            output logic [9:0] sym, output int cout);
      logic [8:0] qm;
      bit xn;
      int ones_d, ones_q, bal, w1;
      ones_d = $countones(d);
      xn = (ones_d > 4) || (ones_d == 4 && d[0] == 1'b0);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = !xn;
      ones_q = $countones(qm[7:0]);
      bal = 2 * ones_q - 8;
      if (cin == 0 || bal == 0) sym = qm[8] ? {2'b01, qm[7:0]} : {2'b10, ~qm[7:0]};
      else if ((cin > 0) == (bal > 0)) sym = {1'b1, qm[8], ~qm[7:0]};
      else sym = {1'b0, qm[8], qm[7:0]};
      // Running disparity is simply the ones-minus-zeros tally of emitted symbols.
      w1 = $countones(sym);
      cout = cin + w1 - (10 - w1);
   endtask

   task automatic model_reset(input int code, input bit dvi, input int sx, input int sy);
      m_code = code;
      m_dvi  = dvi;
      mx     = sx;
      my     = sy;
      mcnt   = '{0, 0, 0};
      exp_q.delete();
      pos_q.delete();
      repeat (2) begin
         exp_q.push_back({T00, T00, T00});
         pos_q.push_back(-1);
      end
   endtask

   task automatic model_push(input logic [23:0] px);
      int w, h, hfp, hs, vfp, vs, fw, fh, c;
      bit neg, act, hsy, vsy, nxt;
      logic [29:0] s;
      logic [9:0] sym;
      if (m_code == 1) begin
         w = 640;  h = 480; hfp = 16;  hs = 96; vfp = 10; vs = 2; fw = 800;  fh = 525; neg = 1;
      end else begin
         w = 1280; h = 720; hfp = 110; hs = 40; vfp = 5;  vs = 5; fw = 1650; fh = 750; neg = 0;
      end
      act = (mx < w) && (my < h);
      hsy = ((mx >= w + hfp) && (mx < w + hfp + hs)) ^ neg;
      vsy = ((my >= h + vfp) && (my < h + vfp + vs)) ^ neg;
      nxt = (my == fh - 1) || (my < h - 1);
      s = '0;
      if (act) begin
         for (int ch = 0; ch < 3; ch++) begin
            enc_model(px[ch*8 +: 8], mcnt[ch], sym, c);
            mcnt[ch] = c;
            s[ch*10 +: 10] = sym;
         end
      end else begin
         mcnt = '{0, 0, 0};
         if (!m_dvi && nxt && mx >= fw - 2) s = {GB, GG, GB};
         else s = {T00, ctok((!m_dvi && nxt && mx >= fw - 10) ? 2'b01 : 2'b00), ctok({vsy, hsy})};
      end
      exp_q.push_back(s);
      pos_q.push_back(my * 2048 + mx);
      mx++;
      if (mx == fw) begin
         mx = 0;
         my++;
         if (my == fh) my = 0;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_m = 1'b1;
      rgb_m = 24'h123456;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (cx_m !== 11'd0) begin failures++; $display("FAIL reset_cx got=%0d exp=0", cx_m); end
      checks++; if (cy_m !== 10'd0) begin failures++; $display("FAIL reset_cy got=%0d exp=0", cy_m); end
      checks++; if (tmds_m !== {T00, T00, T00}) begin failures++; $display("FAIL reset_tmds got=%b exp=%b", tmds_m, {T00, T00, T00}); end
      checks++; if (fw_m !== 11'd1650) begin failures++; $display("FAIL reset_fw got=%0d exp=1650", fw_m); end
      checks++; if (fh_m !== 10'd750) begin failures++; $display("FAIL reset_fh got=%0d exp=750", fh_m); end
      checks++; if (tclk_m !== 10'b0000011111) begin failures++; $display("FAIL reset_tclk got=%b exp=0000011111", tclk_m); end
   endtask

   task automatic test_zero_rgb();
      logic [29:0] e;
      int p;
      rst_m = 1'b0;
      model_reset(4, 1'b0, 0, 0);
      for (int n = 0; n < 1300; n++) begin
         checks++;
         if (cx_m !== 11'(mx) || cy_m !== 10'(my)) begin
            failures++; $display("FAIL zero_pos got=(%0d,%0d) exp=(%0d,%0d)", cx_m, cy_m, mx, my);
         end
         e = exp_q.pop_front();
         p = pos_q.pop_front();
         checks++;
         if (tmds_m !== e) begin failures++; $display("FAIL zero_tmds x=%0d got=%b exp=%b", p, tmds_m, e); end
         if (n >= 2 && n <= 4) begin
            checks++;
            if (tmds_m[9:0] !== ((n == 3) ? 10'b1111111111 : 10'b0100000000)) begin
               failures++; $display("FAIL zero_ch0_seq n=%0d got=%b", n, tmds_m[9:0]);
            end
         end
         if (p == 1280) begin
            checks++;
            if (tmds_m !== {T00, T00, T00}) begin failures++; $display("FAIL zero_first_blank got=%b exp=%b", tmds_m, {T00, T00, T00}); end
         end
         rgb_m = 24'h000000;
         model_push(rgb_m);
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [29:0] e;
      int p;
      rst_m = 1'b1;
      @(negedge clk);
      rst_m = 1'b0;
      model_reset(4, 1'b0, 0, 0);
      for (int n = 0; n < 1400; n++) begin
         checks++;
         if (cx_m !== 11'(mx) || cy_m !== 10'(my)) begin
            failures++; $display("FAIL b2b_pos got=(%0d,%0d) exp=(%0d,%0d)", cx_m, cy_m, mx, my);
         end
         e = exp_q.pop_front();
         p = pos_q.pop_front();
         checks++;
         if (tmds_m !== e) begin failures++; $display("FAIL b2b_tmds x=%0d got=%b exp=%b", p, tmds_m, e); end
         if (n == 2) begin
            checks++;
            if (tmds_m[9:0] !== 10'b1000000000) begin failures++; $display("FAIL b2b_blue_ff got=%b exp=1000000000", tmds_m[9:0]); end
         end
         rgb_m = (n == 0) ? 24'h0000FF : 24'($urandom_range(0, 24'hFFFFFF));
         model_push(rgb_m);
         @(negedge clk);
      end
   endtask

   task automatic test_frame_timing();
      logic [29:0] e, lit;
      bit has_lit;
      int p;
      @(negedge clk);
      checks++; if (cx_f !== 11'd1300 || cy_f !== 10'd724) begin failures++; $display("FAIL frame_start got=(%0d,%0d) exp=(1300,724)", cx_f, cy_f); end
      checks++; if (tmds_f !== {T00, T00, T00}) begin failures++; $display("FAIL frame_reset_tmds got=%b", tmds_f); end
      rst_f = 1'b0;
      model_reset(4, 1'b0, 1300, 724);
      for (int n = 0; n < 41620; n++) begin
         checks++;
         if (cx_f !== 11'(mx) || cy_f !== 10'(my)) begin
            failures++; $display("FAIL frame_pos got=(%0d,%0d) exp=(%0d,%0d)", cx_f, cy_f, mx, my);
         end
         e = exp_q.pop_front();
         p = pos_q.pop_front();
         checks++;
         if (tmds_f !== e) begin failures++; $display("FAIL frame_tmds y=%0d x=%0d got=%b exp=%b", p / 2048, p % 2048, tmds_f, e); end
         has_lit = 1'b1;
         case (p)
            730*2048 + 1389: lit = {T00, T00, T00};
            730*2048 + 1390: lit = {T00, T00, T01};
            730*2048 + 1429: lit = {T00, T00, T01};
            730*2048 + 1430: lit = {T00, T00, T00};
            724*2048 + 1500: lit = {T00, T00, T00};
            725*2048 + 0:    lit = {T00, T00, T10};
            729*2048 + 1390: lit = {T00, T00, T11};
            730*2048 + 0:    lit = {T00, T00, T00};
            748*2048 + 1640: lit = {T00, T00, T00};
            749*2048 + 1639: lit = {T00, T00, T00};
            749*2048 + 1640: lit = {T00, T01, T00};
            749*2048 + 1647: lit = {T00, T01, T00};
            749*2048 + 1648: lit = {GB, GG, GB};
            749*2048 + 1649: lit = {GB, GG, GB};
            default: begin lit = '0; has_lit = 1'b0; end
         endcase
         if (has_lit) begin
            checks++;
            if (tmds_f !== lit) begin failures++; $display("FAIL frame_fixed y=%0d x=%0d got=%b exp=%b", p / 2048, p % 2048, tmds_f, lit); end
         end
         rgb_f = 24'($urandom_range(0, 24'hFFFFFF));
         model_push(rgb_f);
         @(negedge clk);
      end
   endtask

   task automatic test_dvi_vga();
      logic [29:0] e, lit;
      bit has_lit;
      int p;
      @(negedge clk);
      checks++; if (fw_d !== 11'd800) begin failures++; $display("FAIL vga_fw got=%0d exp=800", fw_d); end
      checks++; if (fh_d !== 10'd525) begin failures++; $display("FAIL vga_fh got=%0d exp=525", fh_d); end
      checks++; if (tclk_d !== 10'b0000011111) begin failures++; $display("FAIL vga_tclk got=%b", tclk_d); end
      checks++; if (cx_d !== 11'd600 || cy_d !== 10'd520) begin failures++; $display("FAIL vga_start got=(%0d,%0d) exp=(600,520)", cx_d, cy_d); end
      checks++; if (tmds_d !== {T00, T00, T00}) begin failures++; $display("FAIL vga_reset_tmds got=%b", tmds_d); end
      rst_d = 1'b0;
      model_reset(1, 1'b1, 600, 520);
      for (int n = 0; n < 3420; n++) begin
         checks++;
         if (cx_d !== 11'(mx) || cy_d !== 10'(my)) begin
            failures++; $display("FAIL vga_pos got=(%0d,%0d) exp=(%0d,%0d)", cx_d, cy_d, mx, my);
         end
         e = exp_q.pop_front();
         p = pos_q.pop_front();
         checks++;
         if (tmds_d !== e) begin failures++; $display("FAIL vga_tmds y=%0d x=%0d got=%b exp=%b", p / 2048, p % 2048, tmds_d, e); end
         has_lit = 1'b1;
         case (p)
            522*2048 + 655: lit = {T00, T00, T11};
            522*2048 + 656: lit = {T00, T00, T10};
            522*2048 + 751: lit = {T00, T00, T10};
            522*2048 + 752: lit = {T00, T00, T11};
            524*2048 + 790: lit = {T00, T00, T11};
            524*2048 + 798: lit = {T00, T00, T11};
            524*2048 + 799: lit = {T00, T00, T11};
            default: begin lit = '0; has_lit = 1'b0; end
         endcase
         if (has_lit) begin
            checks++;
            if (tmds_d !== lit) begin failures++; $display("FAIL vga_fixed y=%0d x=%0d got=%b exp=%b", p / 2048, p % 2048, tmds_d, lit); end
         end
         rgb_d = 24'($urandom_range(0, 24'hFFFFFF));
         model_push(rgb_d);
         @(negedge clk);
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_zero_rgb();
      test_back_to_back();
      test_frame_timing();
      test_dvi_vga();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
